page_subdivide_mux: RTL and testbench
=====================================

# page_subdivide_mux

Parametrised leaf-side multiplexer that lets one BFT leaf port serve N_PAGES subdivided child pages. Ingress packets from the BFT are steered to one child by an address field. Egress packets from all children are buffered per child and merged onto the single leaf output by a round-robin arbiter. It sits between the BFT leaf interface and the child page black boxes inside a subdivided parent page. Its registered logic also gives the parent pblock a resident cell.

## Interface
Parameters:
- N_PAGES, 4: number of child pages (2..8).
- PKT_W, 49: packet width. Bit PKT_W-1 is the valid bit.
- SEL_LSB, 43: LSB of the child-select field in a packet. Field width SEL_W = clog2(N_PAGES).
- FIFO_DEPTH, 4: egress FIFO depth per child (power of two, ≥2).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- din_leaf_bft2interface  in  PKT_W  packet from the BFT.
- dout_leaf_interface2bft  out  PKT_W  merged packet to the BFT.
- dout_page_bft2interface  out  N_PAGES*PKT_W  per-child ingress packets. Child i occupies slice [i*PKT_W +: PKT_W].
- din_page_interface2bft  in  N_PAGES*PKT_W  per-child egress packets, same slicing.
- page_en  in  N_PAGES  per-child enable.
- drop_cnt  out  16  saturating count of dropped packets.
- overflow  out  N_PAGES  sticky per-child egress-overflow flags.

## Operation
Ingress path:
- The ingress path is one register stage.
- A valid packet with sel = din[SEL_LSB +: SEL_W] is presented on child sel's slice the next cycle. All other slices carry all-zero.
- If sel ≥ N_PAGES or page_en[sel]=0, the packet is dropped and drop_cnt increments.

Egress FIFOs:
- Child i has its own FIFO_DEPTH-entry FIFO.
- Any cycle in which din_page_interface2bft slice i has its valid bit set and page_en[i]=1 is a push.
- A push to a full FIFO is discarded: overflow[i] is set (sticky until reset) and drop_cnt increments.
- Packets from disabled children are ignored and are not counted.

Arbiter:
- Round-robin over non-empty FIFOs. It pops at most one packet per cycle into the registered dout_leaf_interface2bft.
- The pointer starts at child 0. After a grant to child g, the search resumes at g+1 mod N_PAGES.
- When no FIFO is non-empty, the output is all-zero.
- Arbiter states: IDLE (no FIFO non-empty, output zero) and GRANT (a pop is in progress this cycle). The transition is purely combinational on FIFO emptiness; there is no multi-cycle lock.

Simultaneous events:
- A push and a pop on the same full FIFO in the same cycle succeed: the count stays full and there is no overflow.
- If an ingress drop and an egress overflow occur in the same cycle, drop_cnt increments by 2.
- drop_cnt saturates at 16'hFFFF.

page_en deassertion:
- Deasserting page_en[i] does not flush FIFO i. Already-buffered packets still drain.

Reset:
- Asserting reset at any time immediately clears all FIFOs, the pointers and the arbiter pointer.
- It also forces every output to zero, including drop_cnt and overflow.

## Timing
- Reset value of every output is all-zero.
- Ingress latency: exactly 1 cycle, from din_leaf_bft2interface to dout_page_bft2interface.
- Egress latency: a packet pushed on edge c into an empty FIFO appears on dout_leaf_interface2bft after edge c+1, provided it wins arbitration. Minimum is therefore 2 cycles.
- Egress throughput is 1 packet per cycle aggregate. With K children continuously non-empty, each is granted once every K cycles.
- There is no backpressure on either side. Loss is signalled only through drop_cnt and overflow.

## Test plan
- **Ingress routing:** with page_en=4'b1111, drive 4 packets with sel=0..3 and payload 43'h1..43'h4. Each must appear on the matching child slice 1 cycle later, with the other slices zero, and drop_cnt must stay 0.
- **Ingress drop:** with page_en=4'b1011, send a sel=2 packet. All child slices must stay zero and drop_cnt must become 1.
- **Round-robin:** children 0, 1 and 3 each push 2 packets on the same cycle. The output order must be 0,1,3,0,1,3 on consecutive cycles, starting 2 cycles after the push.
- **Overflow:** child 2 pushes 6 back-to-back packets while children 0, 1 and 3 keep their FIFOs non-empty, so child 2 wins only every 4th cycle. overflow[2]=1 must be set. drop_cnt must equal the number of rejected pushes (1). FIFO contents must drain in order with no corruption.
- **Full push+pop:** fill child 0's FIFO to 4 entries, then push and pop in the same cycle. There must be no overflow, and the 5th packet must emerge in order.
- **Reset mid-operation:** assert reset while 3 FIFOs hold data. All outputs must go to zero asynchronously (before the next edge). After release, the first push emerges after 2 cycles and the arbiter starts from child 0.

Source files
------------

// File: rtl/page_subdivide_mux_if.sv
// Leaf-side bus bundle for page_subdivide_mux: BFT leaf port, per-child page slices,
// enables and loss reporting. The mux takes the slave view; the environment drives the master view.
interface page_subdivide_mux_if #(
    parameter int N_PAGES = 4,
    parameter int PKT_W   = 49
);
    // No valid/ready pair exists on either side: bit PKT_W-1 of a packet is its
    // valid flag, a packet is consumed in the cycle it is presented, and nothing
    // ever stalls. Loss is reported only through drop_cnt and overflow.
    logic [PKT_W-1:0]         din_leaf_bft2interface;
    logic [PKT_W-1:0]         dout_leaf_interface2bft;
    logic [N_PAGES*PKT_W-1:0] dout_page_bft2interface;
    logic [N_PAGES*PKT_W-1:0] din_page_interface2bft;
    logic [N_PAGES-1:0]       page_en;
    logic [15:0]              drop_cnt;
    logic [N_PAGES-1:0]       overflow;
    logic                     arb_state;   // 1 = previous cycle popped a packet

    modport slave (
        input  din_leaf_bft2interface,
        input  din_page_interface2bft,
        input  page_en,
        output dout_leaf_interface2bft,
        output dout_page_bft2interface,
        output drop_cnt,
        output overflow,
        output arb_state
    );

    modport master (
        output din_leaf_bft2interface,
        output din_page_interface2bft,
        output page_en,
        input  dout_leaf_interface2bft,
        input  dout_page_bft2interface,
        input  drop_cnt,
        input  overflow,
        input  arb_state
    );
endinterface

// File: rtl/page_subdivide_mux.sv
// Leaf-side mux for a subdivided page: ingress packets are steered to one child by the
// select field; egress packets are buffered per child and merged by a round-robin arbiter.
module page_subdivide_mux #(
    parameter int N_PAGES    = 4,
    parameter int PKT_W      = 49,
    parameter int SEL_LSB    = 43,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              reset,
    page_subdivide_mux_if.slave bus
);
    localparam int SEL_W = (N_PAGES > 1) ? $clog2(N_PAGES) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // ---------------- ingress ----------------
    logic             in_valid;
    logic [SEL_W-1:0] in_sel;
    logic             route_ok;
    logic             ingress_drop;

    logic [N_PAGES*PKT_W-1:0] page_q;

    assign in_valid = bus.din_leaf_bft2interface[PKT_W-1];
    assign in_sel   = bus.din_leaf_bft2interface[SEL_LSB +: SEL_W];

    // A select value with no matching child (sel >= N_PAGES) never sets route_ok.
    always_comb begin
        route_ok = 1'b0;
        for (int i = 0; i < N_PAGES; i++) begin
            if (in_sel == SEL_W'(i) && bus.page_en[i]) begin
                route_ok = in_valid;
            end
        end
    end

    assign ingress_drop = in_valid && !route_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            page_q <= '0;
        end else begin
            for (int i = 0; i < N_PAGES; i++) begin
                page_q[i*PKT_W +: PKT_W] <= (route_ok && in_sel == SEL_W'(i))
                                            ? bus.din_leaf_bft2interface : '0;
            end
        end
    end

    // ---------------- egress FIFOs ----------------
    logic [PKT_W-1:0] mem [N_PAGES][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr [N_PAGES];
    logic [PTR_W-1:0] rd_ptr [N_PAGES];
    logic [CNT_W-1:0] count  [N_PAGES];

    logic [N_PAGES-1:0] push_req;
    logic [N_PAGES-1:0] not_empty;
    logic [N_PAGES-1:0] full;
    logic [N_PAGES-1:0] push_ok;
    logic [N_PAGES-1:0] ovf_evt;
    logic [N_PAGES-1:0] grant;

    always_comb begin
        push_req  = '0;
        not_empty = '0;
        full      = '0;
        for (int i = 0; i < N_PAGES; i++) begin
            push_req[i]  = bus.din_page_interface2bft[i*PKT_W + PKT_W - 1] && bus.page_en[i];
            not_empty[i] = (count[i] != '0);
            full[i]      = (count[i] == CNT_W'(FIFO_DEPTH));
        end
    end

    // A full FIFO still accepts a push when it is popped in the same cycle.
    always_comb begin
        push_ok = '0;
        ovf_evt = '0;
        for (int i = 0; i < N_PAGES; i++) begin
            push_ok[i] = push_req[i] && (!full[i] || grant[i]);
            ovf_evt[i] = push_req[i] && full[i] && !grant[i];
        end
    end

    // Storage carries no reset: emptiness is defined by the counters alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PAGES; i++) begin
            if (push_ok[i]) begin
                mem[i][wr_ptr[i]] <= bus.din_page_interface2bft[i*PKT_W +: PKT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_PAGES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_PAGES; i++) begin
                if (push_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (grant[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                case ({push_ok[i], grant[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // ---------------- round-robin arbiter ----------------
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant_idx;
    logic             found;
    arb_state_t       arb_next;
    arb_state_t       arb_state_q;
    logic [PKT_W-1:0] leaf_q;

    // Search from rr_ptr upward first, then wrap to the children below it.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        grant     = '0;
        for (int i = 0; i < N_PAGES; i++) begin
            if (!found && not_empty[i] && SEL_W'(i) >= rr_ptr) begin
                found     = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
        for (int i = 0; i < N_PAGES; i++) begin
            if (!found && not_empty[i] && SEL_W'(i) < rr_ptr) begin
                found     = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
        for (int i = 0; i < N_PAGES; i++) begin
            grant[i] = found && (grant_idx == SEL_W'(i));
        end
        arb_next = found ? ARB_GRANT : ARB_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arb_state_q <= ARB_IDLE;
        end else begin
            arb_state_q <= arb_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leaf_q <= '0;
            rr_ptr <= '0;
        end else if (arb_next == ARB_GRANT) begin
            leaf_q <= mem[grant_idx][rd_ptr[grant_idx]];
            rr_ptr <= (grant_idx == SEL_W'(N_PAGES - 1)) ? '0 : grant_idx + 1'b1;
        end else begin
            leaf_q <= '0;
        end
    end

    // ---------------- loss accounting ----------------
    logic [3:0]         drop_inc;
    logic [16:0]        drop_sum;
    logic [15:0]        drop_q;
    logic [N_PAGES-1:0] ovf_q;

    always_comb begin
        drop_inc = 4'(ingress_drop);
        for (int i = 0; i < N_PAGES; i++) begin
            drop_inc = drop_inc + 4'(ovf_evt[i]);
        end
        drop_sum = 17'(drop_q) + 17'(drop_inc);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q <= '0;
            ovf_q  <= '0;
        end else begin
            drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            ovf_q  <= ovf_q | ovf_evt;
        end
    end

    assign bus.dout_page_bft2interface = page_q;
    assign bus.dout_leaf_interface2bft = leaf_q;
    assign bus.drop_cnt                = drop_q;
    assign bus.overflow                = ovf_q;
    assign bus.arb_state               = (arb_state_q == ARB_GRANT);
endmodule

// File: tb/tb_page_subdivide_mux.sv
// Bench for page_subdivide_mux: directed scenarios plus random traffic, compared
// against a queue-based reference model through a cycle-stamped scoreboard.
module tb_page_subdivide_mux;
    localparam int N_PAGES    = 4;
    localparam int PKT_W      = 49;
    localparam int SEL_LSB    = 43;
    localparam int FIFO_DEPTH = 4;
    localparam int SEL_W      = 2;
    localparam int BUS_W      = N_PAGES * PKT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    page_subdivide_mux_if #(.N_PAGES(N_PAGES), .PKT_W(PKT_W)) bus ();

    page_subdivide_mux #(
        .N_PAGES(N_PAGES), .PKT_W(PKT_W), .SEL_LSB(SEL_LSB), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [BUS_W-1:0] act,
                                  input logic [BUS_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [PKT_W-1:0] mk_pkt(input int sel, input int payload);
        logic [PKT_W-1:0] p;
        p = '0;
        p[PKT_W-1] = 1'b1;
        p[SEL_LSB +: SEL_W] = sel[SEL_W-1:0];
        p[31:0] = payload[31:0];
        return p;
    endfunction

    function automatic logic [BUS_W-1:0] put(input logic [BUS_W-1:0] v, input int i,
                                             input logic [PKT_W-1:0] p);
        logic [BUS_W-1:0] r;
        r = v;
        r[i*PKT_W +: PKT_W] = p;
        return r;
    endfunction

    // ---------------- reference model ----------------
    logic [PKT_W-1:0]   m_fifo [N_PAGES][$];
    int                 m_ptr  = 0;
    int                 m_drop = 0;
    logic [N_PAGES-1:0] m_ovf  = '0;
    int                 cyc    = 0;

    logic [BUS_W-1:0] ing_exp_q[$];
    int               ing_cyc_q[$];
    logic [PKT_W-1:0] exp_q[$];
    int               exp_cyc_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PAGES; i++) m_fifo[i].delete();
            m_ptr  = 0;
            m_drop = 0;
            m_ovf  = '0;
            ing_exp_q.delete();
            ing_cyc_q.delete();
            exp_q.delete();
            exp_cyc_q.delete();
        end else begin
            logic [PKT_W-1:0] leaf;
            logic [PKT_W-1:0] pkt;
            logic [BUS_W-1:0] vec;
            int sel;
            int g;
            int lost;
            cyc++;
            lost = 0;
            // ingress: route to an enabled child or count a drop
            leaf = bus.din_leaf_bft2interface;
            if (leaf[PKT_W-1]) begin
                sel = int'(leaf[SEL_LSB +: SEL_W]);
                vec = '0;
                for (int i = 0; i < N_PAGES; i++) begin
                    if (i == sel && bus.page_en[i]) vec = put(vec, i, leaf);
                end
                if (vec != '0) begin
                    ing_exp_q.push_back(vec);
                    ing_cyc_q.push_back(cyc);
                end else begin
                    lost++;
                end
            end
            // egress: pick first non-empty child at or after m_ptr (contents before this edge)
            g = -1;
            for (int k = 0; k < N_PAGES; k++) begin
                for (int i = 0; i < N_PAGES; i++) begin
                    if (g < 0 && i == (m_ptr + k) % N_PAGES && m_fifo[i].size() > 0) g = i;
                end
            end
            for (int i = 0; i < N_PAGES; i++) begin
                if (i == g) begin
                    exp_q.push_back(m_fifo[i].pop_front());
                    exp_cyc_q.push_back(cyc);
                    m_ptr = (g + 1) % N_PAGES;
                end
            end
            for (int i = 0; i < N_PAGES; i++) begin
                pkt = bus.din_page_interface2bft[i*PKT_W +: PKT_W];
                if (pkt[PKT_W-1] && bus.page_en[i]) begin
                    if (m_fifo[i].size() < FIFO_DEPTH) begin
                        m_fifo[i].push_back(pkt);
                    end else begin
                        m_ovf[i] = 1'b1;
                        lost++;
                    end
                end
            end
            m_drop = (m_drop + lost > 65535) ? 65535 : m_drop + lost;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            logic [BUS_W-1:0] exp_pages;
            logic [PKT_W-1:0] exp_leaf;
            exp_pages = '0;
            exp_leaf  = '0;
            if (ing_cyc_q.size() > 0 && ing_cyc_q[0] == cyc) begin
                exp_pages = ing_exp_q.pop_front();
                void'(ing_cyc_q.pop_front());
            end
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                exp_leaf = exp_q.pop_front();
                void'(exp_cyc_q.pop_front());
            end
            check("ingress_slices", bus.dout_page_bft2interface, exp_pages);
            check("egress_leaf", BUS_W'(bus.dout_leaf_interface2bft), BUS_W'(exp_leaf));
            check("drop_cnt", BUS_W'(bus.drop_cnt), BUS_W'(m_drop));
            check("overflow", BUS_W'(bus.overflow), BUS_W'(m_ovf));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_cycle(input logic [PKT_W-1:0] leaf, input logic [BUS_W-1:0] pages);
        @(negedge clk);
        bus.din_leaf_bft2interface = leaf;
        bus.din_page_interface2bft = pages;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.din_leaf_bft2interface = '0;
        bus.din_page_interface2bft = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || ing_exp_q.size() > 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_timeout", BUS_W'(exp_q.size() + ing_exp_q.size()), '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_leaf"}, BUS_W'(bus.dout_leaf_interface2bft), '0);
        check({tag, "_pages"}, bus.dout_page_bft2interface, '0);
        check({tag, "_drop"}, BUS_W'(bus.drop_cnt), '0);
        check({tag, "_ovf"}, BUS_W'(bus.overflow), '0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [BUS_W-1:0] pv;
        logic [PKT_W-1:0] p;
        int order [6];
        order = '{0, 1, 3, 0, 1, 3};

        rst_n = 1'b0;
        bus.din_leaf_bft2interface = '0;
        bus.din_page_interface2bft = '0;
        bus.page_en = 4'b1111;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // ingress routing, one cycle per select value
        set_cycle(mk_pkt(0, 1), '0);
        for (int s = 1; s <= 4; s++) begin
            set_cycle((s < 4) ? mk_pkt(s, s + 1) : '0, '0);
            check("route_slice", bus.dout_page_bft2interface, put('0, s - 1, mk_pkt(s - 1, s)));
        end
        set_cycle('0, '0);
        check("route_drop_cnt", BUS_W'(bus.drop_cnt), '0);

        // ingress drop to a disabled child
        do_reset();
        bus.page_en = 4'b1011;
        set_cycle(mk_pkt(2, 'h55), '0);
        set_cycle('0, '0);
        check("drop_slices", bus.dout_page_bft2interface, '0);
        check("drop_cnt_one", BUS_W'(bus.drop_cnt), BUS_W'(1));
        bus.page_en = 4'b1111;

        // round robin over children 0, 1, 3
        do_reset();
        for (int k = 0; k < 2; k++) begin
            pv = '0;
            pv = put(pv, 0, mk_pkt(0, 'h000 + k));
            pv = put(pv, 1, mk_pkt(1, 'h100 + k));
            pv = put(pv, 3, mk_pkt(3, 'h300 + k));
            set_cycle('0, pv);
        end
        for (int j = 0; j < 6; j++) begin
            set_cycle('0, '0);
            p = mk_pkt(order[j], 'h100 * order[j] + j / 3);
            check("rr_order", BUS_W'(bus.dout_leaf_interface2bft), BUS_W'(p));
        end
        drain();

        // overflow on child 2 while 0, 1, 3 stay busy
        do_reset();
        for (int k = 0; k < 6; k++) begin
            pv = put('0, 2, mk_pkt(2, 'h2000 + k));
            if (k < 2) begin
                pv = put(pv, 0, mk_pkt(0, 'h0100 + k));
                pv = put(pv, 1, mk_pkt(1, 'h1100 + k));
                pv = put(pv, 3, mk_pkt(3, 'h3100 + k));
            end
            set_cycle('0, pv);
        end
        set_cycle('0, '0);
        drain();
        check("ovf_flag", BUS_W'(bus.overflow), BUS_W'(4'b0100));
        check("ovf_drop_cnt", BUS_W'(bus.drop_cnt), BUS_W'(1));

        // child 0 full, push and pop on the same edge
        do_reset();
        for (int k = 0; k < 6; k++) begin
            pv = put('0, 0, mk_pkt(0, 'h5000 + k));
            if (k < 2) begin
                pv = put(pv, 1, mk_pkt(1, 'h5100 + k));
                pv = put(pv, 2, mk_pkt(2, 'h5200 + k));
                pv = put(pv, 3, mk_pkt(3, 'h5300 + k));
            end
            set_cycle('0, pv);
        end
        set_cycle('0, '0);
        drain();
        check("fullpp_ovf", BUS_W'(bus.overflow), '0);
        check("fullpp_drop", BUS_W'(bus.drop_cnt), '0);

        // asynchronous reset while FIFOs hold data
        do_reset();
        for (int k = 0; k < 3; k++) begin
            pv = '0;
            pv = put(pv, 0, mk_pkt(0, 'h6000 + k));
            pv = put(pv, 1, mk_pkt(1, 'h6100 + k));
            pv = put(pv, 2, mk_pkt(2, 'h6200 + k));
            set_cycle(mk_pkt(k, 'h7000 + k), pv);
        end
        set_cycle('0, '0);
        check("pre_reset_busy", BUS_W'(bus.dout_leaf_interface2bft[PKT_W-1]), BUS_W'(1));
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        pv = put('0, 1, mk_pkt(1, 'h8100));
        pv = put(pv, 3, mk_pkt(3, 'h8300));
        set_cycle('0, pv);
        set_cycle('0, '0);
        check("post_reset_lat", BUS_W'(bus.dout_leaf_interface2bft), '0);
        set_cycle('0, '0);
        check("post_reset_first", BUS_W'(bus.dout_leaf_interface2bft), BUS_W'(mk_pkt(1, 'h8100)));
        set_cycle('0, '0);
        check("post_reset_second", BUS_W'(bus.dout_leaf_interface2bft), BUS_W'(mk_pkt(3, 'h8300)));
        drain();

        // random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c % 25 == 0) bus.page_en = 4'($urandom_range(0, 15));
            p = '0;
            if ($urandom_range(0, 1) == 1) p = mk_pkt($urandom_range(0, 3), $urandom);
            pv = '0;
            for (int i = 0; i < N_PAGES; i++) begin
                if ($urandom_range(0, 2) == 0) pv = put(pv, i, mk_pkt($urandom_range(0, 3), $urandom));
            end
            set_cycle(p, pv);
        end
        set_cycle('0, '0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
